// File: rtl/wfunc_apb_loader.sv
// APB initiator that loads window coefficients from an AXI-Stream into the window block, then arms it.
// Optional read-back CRC check of the coefficient memory: define WFUNC_LOADER_VERIFY_EN.
module wfunc_apb_loader #(
  parameter int FFT_SIZE = 8192,
  parameter int APB_AW   = $clog2(FFT_SIZE-1)+3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              one_pack,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [31:0]       s_tdata,
  input  logic              s_tlast,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata
);

  localparam int NW = APB_AW-3;
  localparam logic [APB_AW-1:0] CTRL1  = APB_AW'(FFT_SIZE*4);
  localparam logic [APB_AW-1:0] CTRL2  = APB_AW'((FFT_SIZE+1)*4);
  localparam logic [NW-1:0]     N_LAST = NW'(FFT_SIZE-1);

  typedef enum logic [3:0] {
    IDLE, RST_WR, CFG_WR, COEF, DRAIN, ARM_WR, STAT_RD,
`ifdef WFUNC_LOADER_VERIFY_EN
    VERIFY,
`endif
    DONE
  } state_t;

  state_t            state;
  logic              acc;
  logic [NW-1:0]     n;
  logic [NW-1:0]     n_inc;
  logic              last_q;
  logic              one_pack_q;
  logic              t_rst;
  logic              t_arm;
  logic              psel_q;
  logic [APB_AW-1:0] paddr_q;
  logic [31:0]       pwdata_q;
  logic              coef_wait;

  assign n_inc     = n + NW'(1);
  assign coef_wait = (state == COEF) && !acc;

  // While waiting for a coefficient beat, SETUP is driven straight from the stream so the
  // handshake cycle is also the SETUP cycle; ACCESS then runs from the registered copy.
  assign s_tready = coef_wait || (state == DRAIN);
  assign psel     = psel_q || (coef_wait && s_tvalid);
  assign paddr    = coef_wait ? {1'b0, n, 2'b00} : paddr_q;
  assign pwdata   = coef_wait ? s_tdata : pwdata_q;

`ifdef WFUNC_LOADER_VERIFY_EN
  logic [31:0] crc_w;
  logic [31:0] crc_r;
  logic [31:0] crc_rd_next;

  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_rd_next = crc32_word(crc_r, prdata);
`else
  logic unused_prdata;
  assign unused_prdata = ^{prdata[31:10], prdata[7:0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= 1'b0;
      n          <= '0;
      last_q     <= 1'b0;
      one_pack_q <= 1'b0;
      t_rst      <= 1'b0;
      t_arm      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_code   <= 2'd0;
      psel_q     <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
`ifdef WFUNC_LOADER_VERIFY_EN
      crc_w      <= '1;
      crc_r      <= '1;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            busy       <= 1'b1;
            err_code   <= 2'd0;
            one_pack_q <= one_pack;
            n          <= '0;
            acc        <= 1'b0;
            t_rst      <= ~t_rst;
            psel_q     <= 1'b1;
            penable    <= 1'b0;
            pwrite     <= 1'b1;
            paddr_q    <= CTRL1;
            pwdata_q   <= {23'b0, t_arm, 7'b0, ~t_rst};
`ifdef WFUNC_LOADER_VERIFY_EN
            crc_w      <= '1;
`endif
            state      <= RST_WR;
          end
        end
        RST_WR: begin
          acc     <= ~acc;
          penable <= ~acc;
          if (acc) begin
            paddr_q  <= CTRL2;
            pwdata_q <= {31'b0, one_pack_q};
            state    <= CFG_WR;
          end
        end
        CFG_WR: begin
          acc     <= ~acc;
          penable <= ~acc;
          if (acc) begin
            psel_q <= 1'b0;
            state  <= COEF;
          end
        end
        COEF: begin
          if (!acc) begin
            if (s_tvalid) begin
              psel_q   <= 1'b1;
              penable  <= 1'b1;
              paddr_q  <= {1'b0, n, 2'b00};
              pwdata_q <= s_tdata;
              last_q   <= s_tlast;
              acc      <= 1'b1;
`ifdef WFUNC_LOADER_VERIFY_EN
              crc_w    <= crc32_word(crc_w, s_tdata);
`endif
            end
          end else begin
            acc     <= 1'b0;
            psel_q  <= 1'b0;
            penable <= 1'b0;
            n       <= n_inc;
            if (last_q && (n != N_LAST)) begin
              err_code <= 2'd1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end else if (!last_q && (n == N_LAST)) begin
              err_code <= 2'd2;
              state    <= DRAIN;
            end else if (n == N_LAST) begin
`ifdef WFUNC_LOADER_VERIFY_EN
              psel_q  <= 1'b1;
              pwrite  <= 1'b0;
              paddr_q <= '0;
              n       <= '0;
              crc_r   <= '1;
              state   <= VERIFY;
`else
              t_arm    <= ~t_arm;
              psel_q   <= 1'b1;
              paddr_q  <= CTRL1;
              pwdata_q <= {23'b0, ~t_arm, 7'b0, t_rst};
              state    <= ARM_WR;
`endif
            end
          end
        end
        DRAIN: begin
          if (s_tvalid && s_tlast) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
`ifdef WFUNC_LOADER_VERIFY_EN
        // Read every coefficient back and fold it into a second CRC; arm only if both agree.
        VERIFY: begin
          acc     <= ~acc;
          penable <= ~acc;
          if (acc) begin
            crc_r <= crc_rd_next;
            if (n != N_LAST) begin
              n       <= n_inc;
              paddr_q <= {1'b0, n_inc, 2'b00};
            end else if (crc_rd_next != crc_w) begin
              err_code <= 2'd3;
              psel_q   <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              t_arm    <= ~t_arm;
              pwrite   <= 1'b1;
              paddr_q  <= CTRL1;
              pwdata_q <= {23'b0, ~t_arm, 7'b0, t_rst};
              state    <= ARM_WR;
            end
          end
        end
`endif
        ARM_WR: begin
          acc     <= ~acc;
          penable <= ~acc;
          if (acc) begin
            pwrite   <= 1'b0;
            paddr_q  <= CTRL2;
            pwdata_q <= '0;
            state    <= STAT_RD;
          end
        end
        STAT_RD: begin
          acc     <= ~acc;
          penable <= ~acc;
          if (acc) begin
            psel_q <= 1'b0;
            if (prdata[9:8] != 2'b01) err_code <= 2'd3;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wfunc_apb_loader.sv
// Bench for wfunc_apb_loader: APB responder model, expected-transfer scoreboard, vector table.
module tb_wfunc_apb_loader;

  localparam int FFT_SIZE = 8;
  localparam int APB_AW   = $clog2(FFT_SIZE-1)+3;
  localparam logic [APB_AW-1:0] CTRL1 = APB_AW'(FFT_SIZE*4);
  localparam logic [APB_AW-1:0] CTRL2 = APB_AW'((FFT_SIZE+1)*4);

  logic              clk;
  logic              rst;
  logic              start;
  logic              one_pack;
  logic              busy;
  logic              done;
  logic [1:0]        err_code;
  logic              s_tvalid;
  logic              s_tready;
  logic [31:0]       s_tdata;
  logic              s_tlast;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [APB_AW-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;

  wfunc_apb_loader #(.FFT_SIZE(FFT_SIZE), .APB_AW(APB_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .one_pack(one_pack),
    .busy(busy), .done(done), .err_code(err_code),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [31:0] beat(input int k);
    return {16'(k+1), 16'(k)};
  endfunction

  // Responder model: coefficient memory, ctrl1 change detection, WAIT status after arming.
  logic [31:0] mem [0:FFT_SIZE-1];
  logic [31:0] ctrl1_m;
  logic        armed;
  logic        force_bad;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl1_m <= '0;
      armed   <= 1'b0;
    end else if (psel && penable && pwrite) begin
      if (paddr == CTRL1) begin
        if (pwdata[0] != ctrl1_m[0]) armed <= 1'b0;
        if (pwdata[8] != ctrl1_m[8]) armed <= 1'b1;
        ctrl1_m <= pwdata;
      end
      if (paddr < CTRL1) mem[paddr[4:2]] = pwdata;
    end
  end

  assign prdata = (psel && !pwrite && paddr == CTRL2) ?
                  {22'b0, ((armed && !force_bad) ? 2'b01 : 2'b00), 8'b0} : 32'h0;

  // Scoreboard of expected APB transfers, popped as each ACCESS completes.
  typedef struct {
    logic              wr;
    logic [APB_AW-1:0] addr;
    logic [31:0]       data;
  } apb_t;

  apb_t exp_q[$];
  apb_t mon_item;
  logic              setup_seen = 1'b0;
  logic [APB_AW-1:0] s_addr;
  logic              s_wr;
  logic [31:0]       s_data;
  int                beats_taken = 0;
  logic              abort_stream = 1'b0;
  logic              tb_t_rst = 1'b0;
  logic              tb_t_arm = 1'b0;

  task automatic pushExp(input logic wr, input logic [APB_AW-1:0] addr, input logic [31:0] data);
    exp_q.push_back('{wr, addr, data});
  endtask

  function automatic logic [31:0] ctrl1Word();
    return {23'b0, tb_t_arm, 7'b0, tb_t_rst};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      setup_seen = 1'b0;
    end else begin
      if (psel && !penable) begin
        checkOutput("apb_one_setup", 32'(setup_seen), 32'd0);
        setup_seen = 1'b1;
        s_addr = paddr;
        s_wr   = pwrite;
        s_data = pwdata;
      end else if (psel && penable) begin
        checkOutput("apb_setup_before_access", 32'(setup_seen), 32'd1);
        checkOutput("apb_addr_stable", 32'(paddr), 32'(s_addr));
        checkOutput("apb_write_stable", 32'(pwrite), 32'(s_wr));
        if (pwrite) checkOutput("apb_data_stable", pwdata, s_data);
        if (exp_q.size() == 0) begin
          failNow("apb_unexpected", 32'(paddr), 32'hFFFF_FFFF);
        end else begin
          mon_item = exp_q.pop_front();
          checkOutput("apb_addr", 32'(paddr), 32'(mon_item.addr));
          checkOutput("apb_dir", 32'(pwrite), 32'(mon_item.wr));
          if (mon_item.wr) checkOutput("apb_wdata", pwdata, mon_item.data);
        end
        setup_seen = 1'b0;
      end else begin
        if (penable) failNow("penable_without_psel", 32'(penable), 32'd0);
        if (setup_seen) failNow("setup_without_access", 32'(penable), 32'd1);
        setup_seen = 1'b0;
      end
      if (s_tready)
        checkOutput("psel_gap", 32'(psel), 32'(s_tvalid && (beats_taken < FFT_SIZE)));
    end
  end

  task automatic sendStream(input int nbeats, input int last_beat, input bit toggle);
    int  cyc;
    bit  hs;
    cyc = 0;
    beats_taken = 0;
    while (beats_taken < nbeats && cyc < 400 && !abort_stream) begin
      s_tdata  = beat(beats_taken);
      s_tlast  = (beats_taken + 1 == last_beat);
      s_tvalid = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (hs) beats_taken++;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (beats_taken < nbeats && !abort_stream)
      failNow("stream_timeout", 32'(beats_taken), 32'(nbeats));
  endtask

  task automatic waitDone(output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    while (cycles < 300 && !found) begin
      @(negedge clk);
      cycles++;
      if (done) found = 1'b1;
    end
    if (!found) failNow("done_timeout", 32'(cycles), 32'd0);
  endtask

  typedef struct {
    int         nbeats;
    int         last_beat;
    bit         toggle;
    bit         one_pack;
    bit         bad_state;
    logic [1:0] exp_err;
    int         exp_cycles;
  } vec_t;

  vec_t vecs [5];

  task automatic applyStimulus(input vec_t v);
    int cyc;
    int nw;
    for (int k = 0; k < FFT_SIZE; k++) mem[k] = '0;
    force_bad = v.bad_state;
    nw = (v.nbeats < FFT_SIZE) ? v.nbeats : FFT_SIZE;
    tb_t_rst = ~tb_t_rst;
    pushExp(1'b1, CTRL1, ctrl1Word());
    pushExp(1'b1, CTRL2, {31'b0, v.one_pack});
    for (int k = 0; k < nw; k++) pushExp(1'b1, APB_AW'(k*4), beat(k));
    if (v.exp_err == 2'd0 || v.exp_err == 2'd3) begin
      tb_t_arm = ~tb_t_arm;
      pushExp(1'b1, CTRL1, ctrl1Word());
      pushExp(1'b0, CTRL2, 32'h0);
    end
    one_pack = v.one_pack;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fork
      sendStream(v.nbeats, v.last_beat, v.toggle);
      waitDone(cyc);
    join
    if (v.exp_cycles >= 0) checkOutput("cycles_to_done", 32'(cyc), 32'(v.exp_cycles));
    checkOutput("err_code", 32'(err_code), 32'(v.exp_err));
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("transfers_left", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < FFT_SIZE; k++)
      checkOutput("memory", mem[k], (k < nw) ? beat(k) : 32'h0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit found;
    rst = 1'b0; start = 1'b0; one_pack = 1'b0; force_bad = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    #2 rst = 1'b1;
    #10;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_psel", 32'(psel), 32'd0);
    checkOutput("rst_penable", 32'(penable), 32'd0);
    checkOutput("rst_pwrite", 32'(pwrite), 32'd0);
    checkOutput("rst_tready", 32'(s_tready), 32'd0);
    checkOutput("rst_paddr", 32'(paddr), 32'd0);
    checkOutput("rst_pwdata", pwdata, 32'd0);
    checkOutput("rst_err", 32'(err_code), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // nbeats, last_beat, toggle, one_pack, bad_state, exp_err, exp_cycles
    vecs[0] = '{8,  8,  1'b0, 1'b1, 1'b0, 2'd0, 25};
    vecs[1] = '{5,  5,  1'b0, 1'b1, 1'b0, 2'd1, 15};
    vecs[2] = '{11, 11, 1'b0, 1'b1, 1'b0, 2'd2, 24};
    vecs[3] = '{8,  8,  1'b1, 1'b0, 1'b0, 2'd0, -1};
    vecs[4] = '{8,  8,  1'b0, 1'b1, 1'b1, 2'd3, 25};
    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    $display("[TB] reset during coefficient 4 access");
    for (int k = 0; k < FFT_SIZE; k++) mem[k] = '0;
    force_bad = 1'b0;
    tb_t_rst = ~tb_t_rst;
    pushExp(1'b1, CTRL1, ctrl1Word());
    pushExp(1'b1, CTRL2, 32'h1);
    for (int k = 0; k < FFT_SIZE; k++) pushExp(1'b1, APB_AW'(k*4), beat(k));
    one_pack = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fork
      sendStream(FFT_SIZE, FFT_SIZE, 1'b0);
      begin
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
          @(negedge clk);
          if (psel && penable && paddr == APB_AW'(12)) found = 1'b1;
        end
        if (!found) failNow("reset_point_timeout", 32'(paddr), 32'd12);
        #1 rst = 1'b1;
        abort_stream = 1'b1;
        #1;
        checkOutput("async_psel", 32'(psel), 32'd0);
        checkOutput("async_penable", 32'(penable), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_tready", 32'(s_tready), 32'd0);
        checkOutput("async_paddr", 32'(paddr), 32'd0);
      end
    join
    exp_q.delete();
    tb_t_rst = 1'b0;
    tb_t_arm = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    abort_stream = 1'b0;
    checkOutput("mem_before_reset", mem[2], beat(2));
    checkOutput("no_write_after_reset", mem[3], 32'h0);
    applyStimulus(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
